mmio_periph: RTL and testbench
==============================

# mmio_periph

Parametrised memory-mapped peripheral block between the CPU data-memory bus (mem_cmd / mem_addr / write_data) and the board I/O. Replaces the ad-hoc LED register and tristated switch reader with one registered-read slave that adds switch synchronisation and debouncing, sticky change flags with write-1-to-clear, a hex-display register and an interrupt output. RAM decode stays outside; this block only answers its own addresses and reports a hit.

## Interface

Parameters:
- LED_W, 8, LED register width (1..16)
- SW_W, 8, switch count (1..16)
- DB_CYCLES, 4, consecutive stable cycles required to accept a switch change (>=1)
- LED_ADDR, 9'h100, LED register address
- SW_ADDR, 9'h140, base of switch register group (SW, SW_CHG, IRQ_EN at +0, +1, +2)
- HEX_ADDR, 9'h108, hex display register address

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_cmd  in  2  NONE=00, READ=01, WRITE=10; 11 treated as NONE
- mem_addr  in  9  word address
- write_data  in  16  store data
- read_data  out  16  registered read data
- rd_hit  out  1  registered: previous cycle was a READ to a mapped address
- sw_in  in  SW_W  raw asynchronous switches
- ledr  out  LED_W  LED register
- hex_value  out  16  hex display register
- irq  out  1  OR of (SW_CHG & IRQ_EN)

## Operation

- Register map: LED (RW, LED_W bits), HEX (RW, 16), SW (RO, debounced value), SW_CHG (RW1C sticky), IRQ_EN (RW, SW_W bits). Reads zero-extend to 16 bits.
- Writes: on WRITE to a mapped RW address, register loads write_data low bits. Writes to SW are ignored. Writes to unmapped addresses ignored.
- Reads: every cycle, rd_hit <= (READ && addr mapped); read_data <= mapped value, or 16'h0000 when not a mapped READ. Never high-Z. Reading SW_CHG does not clear it.
- Switch path per bit: 2-flop synchroniser -> debouncer. Debouncer holds accepted value db[i] and counter cnt[i] (width clog2(DB_CYCLES+1)). If sync[i]==db[i]: cnt<=0. Else cnt increments; when cnt reaches DB_CYCLES-1 and sync still differs, db[i] toggles and cnt<=0 on that edge. A glitch shorter than DB_CYCLES cycles never changes db.
- SW_CHG[i] sets on the edge db[i] toggles. WRITE to SW_CHG clears bits where write_data is 1. Set and clear same cycle: set wins.
- irq is combinational from SW_CHG and IRQ_EN registers (no glitch from bus inputs).

## Timing

- Reset (async assert, released sync to clk): ledr=0, hex_value=0, read_data=0, rd_hit=0, SW_CHG=0, IRQ_EN=0, irq=0, sync flops=0, db=0, cnt=0. After reset, switches held high are accepted as a change (SW_CHG sets) — intended.
- Write: register visible on outputs the cycle after the WRITE edge.
- Read: read_data/rd_hit valid exactly one cycle after the READ cycle; back-to-back reads return one result per cycle. Read of a register in the same cycle it is written returns the old value.
- Switch latency: stable sw_in change -> db update 2 + DB_CYCLES edges later; SW_CHG and irq on the same edge.
- Reset mid-debounce discards partial count.

## Structure

- Package mmio_pkg: mem_cmd_t enum (MEM_NONE, MEM_READ, MEM_WRITE), default address constants, register offset constants.
- Sub-module sw_debounce (one per switch via generate): synchroniser + counter + db output + toggle pulse, parameter DB_CYCLES.
- Top holds decode, registers, read mux, sticky flags.

## Test plan

- Reset with sw_in=8'hA5 -> all outputs 0; after 2+4 cycles SW reads 16'h00A5, SW_CHG reads 16'h00A5.
- WRITE 16'hFF3C to 9'h100, then READ 9'h100 -> ledr=8'h3C next cycle; read_data=16'h003C, rd_hit=1 one cycle after READ.
- Pulse sw_in[0] high for 3 cycles (DB_CYCLES=4) -> SW unchanged, SW_CHG unchanged; hold 4+ cycles -> SW[0]=1, SW_CHG[0]=1.
- IRQ_EN=16'h0001, SW_CHG[0] set -> irq=1; WRITE 16'h0001 to SW_CHG -> irq=0 next cycle; coincident new toggle on same edge -> bit stays 1.
- READ 9'h0050 (unmapped) -> rd_hit=0, read_data=16'h0000; WRITE to SW address -> SW unchanged.
- Assert reset mid-count and mid-LED value 8'h3C -> ledr=0 immediately (async), debouncer restarts from 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and address constants for the memory-mapped peripheral block.
package mmio_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;
  localparam logic [8:0] HEX_ADDR_DEF = 9'h108;

  localparam logic [8:0] SW_OFF     = 9'd0;
  localparam logic [8:0] SW_CHG_OFF = 9'd1;
  localparam logic [8:0] IRQ_EN_OFF = 9'd2;

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-flop synchroniser followed by a counter debouncer.
// toggle pulses high in the cycle whose rising edge flips db.
module sw_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic db,
  output logic toggle
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync0_q, sync0_d;
  logic          sync1_q, sync1_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sync0_d = sw_raw;
    sync1_d = sync0_q;
    db_d    = db_q;
    cnt_d   = '0;
    toggle  = 1'b0;
    // Accept on the DB_CYCLES-th consecutive cycle of disagreement.
    if (sync1_q != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d   = ~db_q;
        toggle = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign db = db_q;

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped LED/HEX/switch peripheral with registered reads,
// debounced switches, sticky W1C change flags and an interrupt output.
module mmio_periph
  import mmio_pkg::*;
#(
  parameter int unsigned LED_W     = 8,
  parameter int unsigned SW_W      = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter logic [8:0]  LED_ADDR  = LED_ADDR_DEF,
  parameter logic [8:0]  SW_ADDR   = SW_ADDR_DEF,
  parameter logic [8:0]  HEX_ADDR  = HEX_ADDR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mem_cmd,
  input  logic [8:0]       mem_addr,
  input  logic [15:0]      write_data,
  output logic [15:0]      read_data,
  output logic             rd_hit,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] ledr,
  output logic [15:0]      hex_value,
  output logic             irq
);

  localparam logic [8:0] SW_REG_ADDR  = SW_ADDR + SW_OFF;
  localparam logic [8:0] CHG_REG_ADDR = SW_ADDR + SW_CHG_OFF;
  localparam logic [8:0] EN_REG_ADDR  = SW_ADDR + IRQ_EN_OFF;

  mem_cmd_t         cmd;
  logic             is_rd, is_wr;
  logic             hit_led, hit_hex, hit_sw, hit_chg, hit_en, mapped;
  logic [15:0]      rdata;

  logic [LED_W-1:0] led_q, led_d;
  logic [15:0]      hex_q, hex_d;
  logic [SW_W-1:0]  irq_en_q, irq_en_d;
  logic [SW_W-1:0]  sw_chg_q, sw_chg_d;
  logic [15:0]      read_data_q, read_data_d;
  logic             rd_hit_q, rd_hit_d;

  logic [SW_W-1:0]  db;
  logic [SW_W-1:0]  tog;

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_sw_debounce (
      .clk   (clk),
      .reset (reset),
      .sw_raw(sw_in[i]),
      .db    (db[i]),
      .toggle(tog[i])
    );
  end

  always_comb begin
    cmd     = mem_cmd_t'(mem_cmd);
    is_rd   = (cmd == MEM_READ);
    is_wr   = (cmd == MEM_WRITE);
    hit_led = (mem_addr == LED_ADDR);
    hit_hex = (mem_addr == HEX_ADDR);
    hit_sw  = (mem_addr == SW_REG_ADDR);
    hit_chg = (mem_addr == CHG_REG_ADDR);
    hit_en  = (mem_addr == EN_REG_ADDR);
    mapped  = hit_led | hit_hex | hit_sw | hit_chg | hit_en;
  end

  always_comb begin
    rdata = '0;
    if (hit_led)      rdata[LED_W-1:0] = led_q;
    else if (hit_hex) rdata            = hex_q;
    else if (hit_sw)  rdata[SW_W-1:0]  = db;
    else if (hit_chg) rdata[SW_W-1:0]  = sw_chg_q;
    else if (hit_en)  rdata[SW_W-1:0]  = irq_en_q;
    read_data_d = (is_rd && mapped) ? rdata : '0;
    rd_hit_d    = is_rd && mapped;
  end

  always_comb begin
    led_d    = led_q;
    hex_d    = hex_q;
    irq_en_d = irq_en_q;
    sw_chg_d = sw_chg_q;
    if (is_wr && hit_led) led_d    = LED_W'(write_data);
    if (is_wr && hit_hex) hex_d    = write_data;
    if (is_wr && hit_en)  irq_en_d = SW_W'(write_data);
    if (is_wr && hit_chg) sw_chg_d = sw_chg_q & ~SW_W'(write_data);
    // Applied after the clear so a coincident new toggle keeps its flag.
    sw_chg_d = sw_chg_d | tog;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q       <= '0;
      hex_q       <= '0;
      irq_en_q    <= '0;
      sw_chg_q    <= '0;
      read_data_q <= '0;
      rd_hit_q    <= 1'b0;
    end else begin
      led_q       <= led_d;
      hex_q       <= hex_d;
      irq_en_q    <= irq_en_d;
      sw_chg_q    <= sw_chg_d;
      read_data_q <= read_data_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  assign ledr      = led_q;
  assign hex_value = hex_q;
  assign read_data = read_data_q;
  assign rd_hit    = rd_hit_q;
  assign irq       = |(sw_chg_q & irq_en_q);

endmodule

// File: tb/tb_mmio_periph.sv
// Self-checking bench for mmio_periph: directed table, multi-cycle corner
// sequences and randomized bus/switch traffic against a register-map model.
module tb_mmio_periph;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = 2'b00;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;
  logic        rd_hit;
  logic [7:0]  sw_in = '0;
  logic [7:0]  ledr;
  logic [15:0] hex_value;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_periph #(
    .LED_W    (8),
    .SW_W     (8),
    .DB_CYCLES(4),
    .LED_ADDR (9'h100),
    .SW_ADDR  (9'h140),
    .HEX_ADDR (9'h108)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .rd_hit    (rd_hit),
    .sw_in     (sw_in),
    .ledr      (ledr),
    .hex_value (hex_value),
    .irq       (irq)
  );

  localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_BAD = 2'b11;

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    logic        hit;
    logic [7:0]  led;
    logic [15:0] hex;
    logic        irq;
  } vec_t;

  vec_t tbl[16];

  // Reference state for the randomized phase.
  logic [7:0]  m_led, m_en, m_chg, m_db;
  logic [15:0] m_hex;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, take one rising edge, settle.
  task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(C_NONE, 9'h000, 16'h0000);
  endtask

  task automatic do_reset(input logic [7:0] sw);
    sw_in   = sw;
    mem_cmd = C_NONE;
    #3 reset = 1'b1;
    #1;
    chk("rst_ledr", {8'h00, ledr}, 16'h0000);
    chk("rst_hex", hex_value, 16'h0000);
    chk("rst_rdata", read_data, 16'h0000);
    chk("rst_rdhit", {15'b0, rd_hit}, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    idle(5);
    drive(C_RD, 9'h140, 16'h0);
    chk("sw_before_accept", read_data, 16'h0000);
    drive(C_RD, 9'h140, 16'h0);
    chk("sw_after_accept", read_data, {8'h00, sw});
    drive(C_RD, 9'h141, 16'h0);
    chk("chg_after_reset", read_data, {8'h00, sw});
  endtask

  task automatic rstep(input logic [1:0] c, input logic [8:0] a, input logic [15:0] w,
                       input bit upd, input logic [7:0] new_db);
    logic [15:0] ev;
    logic        eh;
    eh = 1'b1;
    case (a)
      9'h100:  ev = {8'h00, m_led};
      9'h108:  ev = m_hex;
      9'h140:  ev = {8'h00, m_db};
      9'h141:  ev = {8'h00, m_chg};
      9'h142:  ev = {8'h00, m_en};
      default: begin ev = 16'h0000; eh = 1'b0; end
    endcase
    if (c != C_RD) begin ev = 16'h0000; eh = 1'b0; end
    drive(c, a, w);
    if (c == C_WR) begin
      case (a)
        9'h100:  m_led = w[7:0];
        9'h108:  m_hex = w;
        9'h141:  m_chg = m_chg & ~w[7:0];
        9'h142:  m_en  = w[7:0];
        default: ;
      endcase
    end
    if (upd) begin
      m_chg = m_chg | (new_db ^ m_db);
      m_db  = new_db;
    end
    chk("rnd_rdata", read_data, ev);
    chk("rnd_rdhit", {15'b0, rd_hit}, {15'b0, eh});
    chk("rnd_ledr", {8'h00, ledr}, {8'h00, m_led});
    chk("rnd_hex", hex_value, m_hex);
    chk("rnd_irq", {15'b0, irq}, {15'b0, |(m_chg & m_en)});
  endtask

  initial begin
    tbl[0]  = '{C_WR,   9'h100, 16'hFF3C, 16'h0000, 1'b0, 8'h3C, 16'h0000, 1'b0};
    tbl[1]  = '{C_RD,   9'h100, 16'h0000, 16'h003C, 1'b1, 8'h3C, 16'h0000, 1'b0};
    tbl[2]  = '{C_WR,   9'h108, 16'hBEEF, 16'h0000, 1'b0, 8'h3C, 16'hBEEF, 1'b0};
    tbl[3]  = '{C_RD,   9'h108, 16'h0000, 16'hBEEF, 1'b1, 8'h3C, 16'hBEEF, 1'b0};
    tbl[4]  = '{C_RD,   9'h050, 16'h0000, 16'h0000, 1'b0, 8'h3C, 16'hBEEF, 1'b0};
    tbl[5]  = '{C_WR,   9'h140, 16'hFFFF, 16'h0000, 1'b0, 8'h3C, 16'hBEEF, 1'b0};
    tbl[6]  = '{C_RD,   9'h140, 16'h0000, 16'h00A5, 1'b1, 8'h3C, 16'hBEEF, 1'b0};
    tbl[7]  = '{C_WR,   9'h141, 16'h0005, 16'h0000, 1'b0, 8'h3C, 16'hBEEF, 1'b0};
    tbl[8]  = '{C_RD,   9'h141, 16'h0000, 16'h00A0, 1'b1, 8'h3C, 16'hBEEF, 1'b0};
    tbl[9]  = '{C_BAD,  9'h100, 16'h0000, 16'h0000, 1'b0, 8'h3C, 16'hBEEF, 1'b0};
    tbl[10] = '{C_WR,   9'h100, 16'h0012, 16'h0000, 1'b0, 8'h12, 16'hBEEF, 1'b0};
    tbl[11] = '{C_RD,   9'h100, 16'h0000, 16'h0012, 1'b1, 8'h12, 16'hBEEF, 1'b0};
    tbl[12] = '{C_WR,   9'h142, 16'hFFFF, 16'h0000, 1'b0, 8'h12, 16'hBEEF, 1'b1};
    tbl[13] = '{C_RD,   9'h142, 16'h0000, 16'h00FF, 1'b1, 8'h12, 16'hBEEF, 1'b1};
    tbl[14] = '{C_WR,   9'h141, 16'hFFFF, 16'h0000, 1'b0, 8'h12, 16'hBEEF, 1'b0};
    tbl[15] = '{C_RD,   9'h141, 16'h0000, 16'h0000, 1'b1, 8'h12, 16'hBEEF, 1'b0};

    do_reset(8'hA5);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].cmd, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_rdata", i), read_data, tbl[i].rd);
      chk($sformatf("tbl%0d_rdhit", i), {15'b0, rd_hit}, {15'b0, tbl[i].hit});
      chk($sformatf("tbl%0d_ledr", i), {8'h00, ledr}, {8'h00, tbl[i].led});
      chk($sformatf("tbl%0d_hex", i), hex_value, tbl[i].hex);
      chk($sformatf("tbl%0d_irq", i), {15'b0, irq}, {15'b0, tbl[i].irq});
    end

    // Switch bit 0 falls and is accepted; clear its flag.
    drive(C_WR, 9'h142, 16'h0001);
    sw_in = 8'hA4;
    idle(10);
    chk("fall_irq", {15'b0, irq}, 16'h0001);
    drive(C_WR, 9'h141, 16'h0001);
    chk("w1c_irq", {15'b0, irq}, 16'h0000);

    // Three-cycle glitch must be rejected.
    sw_in = 8'hA5;
    idle(3);
    sw_in = 8'hA4;
    idle(6);
    drive(C_RD, 9'h140, 16'h0);
    chk("glitch_sw", read_data, 16'h00A4);
    drive(C_RD, 9'h141, 16'h0);
    chk("glitch_chg", read_data, 16'h0000);
    chk("glitch_irq", {15'b0, irq}, 16'h0000);

    // Held change is accepted exactly on the sixth edge.
    sw_in = 8'hA5;
    idle(5);
    chk("hold_irq_early", {15'b0, irq}, 16'h0000);
    idle(1);
    chk("hold_irq_edge6", {15'b0, irq}, 16'h0001);
    drive(C_RD, 9'h140, 16'h0);
    chk("hold_sw", read_data, 16'h00A5);

    // Clear coinciding with a new toggle: the set wins.
    sw_in = 8'hA4;
    idle(5);
    chk("coinc_irq_pre", {15'b0, irq}, 16'h0001);
    drive(C_WR, 9'h141, 16'h0001);
    chk("coinc_irq", {15'b0, irq}, 16'h0001);
    drive(C_RD, 9'h141, 16'h0);
    chk("coinc_chg", read_data, 16'h0001);
    drive(C_WR, 9'h141, 16'h0001);
    chk("clear_irq", {15'b0, irq}, 16'h0000);

    // Reset in the middle of a debounce count with LEDs lit.
    drive(C_WR, 9'h100, 16'h003C);
    chk("led_before_rst", {8'h00, ledr}, 16'h003C);
    sw_in = 8'hA6;
    idle(4);
    do_reset(8'hA6);

    m_led = '0; m_hex = '0; m_en = '0; m_chg = 8'hA6; m_db = 8'hA6;
    for (int ep = 0; ep < 20; ep++) begin
      logic [7:0]  nv, gm;
      logic [8:0]  addrs[6];
      int unsigned g;
      addrs = '{9'h100, 9'h108, 9'h140, 9'h141, 9'h142, 9'h050};
      nv = 8'($urandom);
      gm = 8'($urandom);
      g  = $urandom_range(1, 3);
      for (int c = 0; c < 16; c++) begin
        logic [1:0]  rc;
        logic [8:0]  ra;
        int unsigned ai;
        if (c == 0) sw_in = nv;
        if (c == 9) sw_in = nv ^ gm;
        if (c == 9 + int'(g)) sw_in = nv;
        rc = 2'($urandom_range(0, 3));
        ai = $urandom_range(0, 6);
        ra = (ai < 6) ? addrs[ai] : 9'($urandom);
        rstep(rc, ra, 16'($urandom), (c == 5), nv);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
